// File: rtl/imem_boot_loader.sv
// Boot loader: LEN_LO, LEN_HI, 4*N payload bytes, XOR checksum byte.
// Ports: clk/rst_n/restart, s_valid/s_data/s_ready, imem_*, core_rst_n/busy/error.
module imem_boot_loader #(
  parameter int INST_MEMORY_ADDR_BUS_WIDTH = 16,
  parameter int INST_MEMORY_DATA_BUS_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  restart,
  input  logic                                  s_valid,
  input  logic [7:0]                            s_data,
  output logic                                  s_ready,
  output logic                                  imem_we,
  output logic [INST_MEMORY_ADDR_BUS_WIDTH-1:0] imem_addr,
  output logic [INST_MEMORY_DATA_BUS_WIDTH-1:0] imem_wdata,
  output logic                                  core_rst_n,
  output logic                                  busy,
  output logic                                  error
);

  localparam int AW = INST_MEMORY_ADDR_BUS_WIDTH;
  localparam int DW = INST_MEMORY_DATA_BUS_WIDTH;
  localparam int WW = AW - 2;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state;
  state_t state_nx;

  logic          armed;
  logic [15:0]   len;
  logic [WW-1:0] word_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   asm_q;
  logic [7:0]    csum;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic          in_load;
  logic          xfer;
  logic [15:0]   len_nx;
  logic [31:0]   max_words;
  logic          oversize;
  logic          last_word;
  logic [WW-1:0] word_one;

  assign in_load = (state == S_LEN_LO) ||
                   (state == S_LEN_HI) ||
                   (state == S_DATA)   ||
                   (state == S_CHECK);

  // armed keeps s_ready low while rst_n is held,
  // even though the state already reads LEN_LO.
  assign s_ready = armed & in_load;
  assign xfer    = s_valid & s_ready;

  assign len_nx    = {s_data, len[7:0]};
  assign max_words = 32'(1) << WW;
  assign oversize  = 32'(len_nx) > max_words;
  assign last_word = (32'(word_idx) + 32'd1)
                     == 32'(len);
  assign word_one  = {{(WW-1){1'b0}}, 1'b1};

  assign busy       = in_load;
  assign error      = (state == S_ERROR);
  assign core_rst_n = (state == S_DONE);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LEN_LO;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (restart) begin
      state_nx = S_LEN_LO;
    end else if (xfer) begin
      unique case (state)
        S_LEN_LO: state_nx = S_LEN_HI;
        S_LEN_HI: begin
          if (oversize) begin
            state_nx = S_ERROR;
          end else if (len_nx == 16'd0) begin
            state_nx = S_CHECK;
          end else begin
            state_nx = S_DATA;
          end
        end
        S_DATA: begin
          if (byte_idx == 2'd3 && last_word) begin
            state_nx = S_CHECK;
          end
        end
        S_CHECK: begin
          if (s_data == csum) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_ERROR;
          end
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      len      <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      asm_q    <= '0;
      csum     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      armed <= 1'b1;
      we_q  <= 1'b0;
      // A word completed just before restart has
      // already set we_q, so its write still lands.
      if (restart) begin
        len      <= '0;
        word_idx <= '0;
        byte_idx <= '0;
        asm_q    <= '0;
        csum     <= '0;
      end else if (xfer) begin
        unique case (state)
          S_LEN_LO: len[7:0] <= s_data;
          S_LEN_HI: begin
            len[15:8] <= s_data;
            word_idx  <= '0;
            byte_idx  <= '0;
          end
          S_DATA: begin
            csum     <= csum ^ s_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              we_q     <= 1'b1;
              addr_q   <= {word_idx, 2'b00};
              wdata_q  <= DW'({s_data, asm_q});
              word_idx <= word_idx + word_one;
            end else begin
              asm_q[{byte_idx, 3'b000} +: 8]
                <= s_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time loader that sits directly upstream of the instruction memory and processor core.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory through a write port.
- Holds the core in reset until a complete image with a valid checksum has been loaded, then releases it.

Parameters:
- INST_MEMORY_ADDR_BUS_WIDTH, 16, byte-address width of instruction memory; matches the core PC width.
- INST_MEMORY_DATA_BUS_WIDTH, 32, instruction word width; fixed at 32, 4 bytes per word.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- restart  input  1  synchronous pulse; aborts any load and re-arms the loader.
- s_valid  input  1  byte stream valid.
- s_data  input  8  byte stream data.
- s_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- imem_addr  output  INST_MEMORY_ADDR_BUS_WIDTH  byte address of the word being written; always a multiple of 4.
- imem_wdata  output  INST_MEMORY_DATA_BUS_WIDTH  assembled instruction word.
- core_rst_n  output  1  active-low reset to the core; high only in DONE.
- busy  output  1  high in LEN_LO, LEN_HI, DATA and CHECK.
- error  output  1  sticky load-failure flag.

Behaviour:
- Reset:
  - rst_n low forces state LEN_LO immediately (asynchronous).
  - Outputs while reset is held: s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, busy=1, error=0.
  - Internal state cleared: word counter, byte counter, length register, checksum.
  - From the first clock after release, s_ready=1.
- Handshake: a byte transfers on a rising edge where s_valid=1 and s_ready=1. s_ready is 1 in LEN_LO, LEN_HI, DATA and CHECK, and 0 in DONE and ERROR. There is no stall inside DATA.
- Frame format: LEN_LO byte, LEN_HI byte (16-bit word count N, little-endian), then 4*N payload bytes, then one checksum byte.
- Checksum: the XOR of all payload bytes. Length bytes are excluded.
- State LEN_LO: the accepted byte goes to len[7:0]. Next state is LEN_HI.
- State LEN_HI: the accepted byte goes to len[15:8], and {byte, len[7:0]} is evaluated:
  - N > 2^(INST_MEMORY_ADDR_BUS_WIDTH-2) goes to ERROR.
  - N = 0 goes to CHECK.
  - Otherwise go to DATA with word index 0 and byte index 0.
- State DATA:
  - Byte k (0..3) of the current word fills bits [8k+7:8k]; each accepted byte is XORed into the checksum.
  - On acceptance of byte 3, the next cycle drives imem_we=1, imem_wdata=the assembled word and imem_addr=word_index*4.
  - The word index increments with that write pulse.
  - After the write for word N-1, the state moves to CHECK. A byte may be accepted in CHECK on the same cycle as that final imem_we pulse.
- State CHECK: the accepted byte is compared with the running checksum. On a match go to DONE; on a mismatch go to ERROR.
- State DONE: core_rst_n=1, busy=0. The state holds until restart or rst_n.
- State ERROR: error=1, core_rst_n=0, busy=0. The state holds until restart or rst_n.
- restart:
  - Effect: in any state, on the next edge go to LEN_LO and clear the counters, checksum and error. core_rst_n drops to 0 on that same edge.
  - Priority: restart has priority over a simultaneous byte transfer, and that byte is discarded.
  - A pending imem_we pulse for a word already completed is still issued.
- imem_addr and imem_wdata hold their last written values when imem_we=0.
- Address arithmetic: word_index*4, truncated to INST_MEMORY_ADDR_BUS_WIDTH. It cannot wrap because of the N limit.
- Latency: 1 cycle from the 4th byte acceptance to imem_we. core_rst_n rises on the edge that accepts a matching checksum byte.

Test Plan:
- Normal load: stream 02 00 | 93 00 10 00 | 13 01 20 00 | checksum 0xB1 (XOR of the 8 payload bytes).
  - Required: imem_we pulses twice: addr 0x0000 data 0x00100093, then addr 0x0004 data 0x00200113.
  - Required: core_rst_n=1 after the checksum byte; error=0.
- Bad checksum: same frame with checksum 0x00.
  - Required: error=1, core_rst_n stays 0, s_ready=0, both words still written.
- Zero length: stream 00 00 00.
  - Required: no imem_we pulse; DONE reached after 3 bytes; core_rst_n=1.
- Oversize length: N=0x4001 (bytes 01 40) with default width.
  - Required: ERROR immediately after LEN_HI; no writes.
- Backpressure gaps: random s_valid gaps of 0-5 cycles during the normal load.
  - Required: identical writes and final state; no byte dropped or duplicated.
- Abort recovery:
  - Stimulus: restart asserted after 3 payload bytes, then a full frame N=1 with payload EF BE AD DE and checksum 0x22.
  - Required: a single write, addr 0 data 0xDEADBEEF; DONE.
  - Stimulus: rst_n asserted mid-DATA.
  - Required: outputs return to their reset values immediately (asynchronously).
